prbs_test_ctrl: RTL and testbench

PRBS_TEST_CTRL -- requirements
Module: prbs_test_ctrl

---
 rtl/prbs_pkg.sv | 19 +
 rtl/prbs_pat_regs.sv | 29 ++
 rtl/prbs_test_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_prbs_test_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// Shared types and constants for the PRBS test controller.
// Optional CHECK timeout is enabled by defining PRBS_CTRL_TIMEOUT_EN.
package prbs_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FEED,
    ST_PRBS_RUN,
    ST_CHECK,
    ST_DONE
  } state_t;

  localparam int unsigned BYTE_IDX_W      = 2;
  localparam int unsigned PAT_DEPTH       = 4;
  localparam int unsigned DEF_DET_LAT     = 2;
  localparam int unsigned DEF_TIMEOUT_CYC = 64;

endpackage

// File: rtl/prbs_pat_regs.sv
// 4x8 pattern register file: one synchronous write port, one async read index.
module prbs_pat_regs
  import prbs_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [BYTE_IDX_W-1:0] wr_addr,
  input  logic [7:0]            wr_data,
  input  logic [BYTE_IDX_W-1:0] rd_idx,
  output logic [7:0]            rd_data
);

  logic [7:0] mem [PAT_DEPTH];

  // Pattern bytes: cleared on reset, written one byte per strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < PAT_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/prbs_test_ctrl.sv
// PRBS test sequencer: clears the datapath, feeds the 4-byte pattern N times,
// runs the PRBS generator prbs_len cycles, then evaluates the detector flag.
// Define PRBS_CTRL_TIMEOUT_EN to wait for det_flag up to TIMEOUT_CYC cycles
// instead of sampling it after a fixed DET_LAT cycles.
module prbs_test_ctrl
  import prbs_pkg::*;
#(
  parameter int unsigned DET_LAT     = DEF_DET_LAT,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_wr,
  input  logic [1:0]  cfg_addr,
  input  logic [7:0]  cfg_data,
  input  logic [7:0]  N,
  input  logic [15:0] prbs_len,
  input  logic        start,
  input  logic        abort,
  input  logic        det_flag,
  output logic        dp_rst,
  output logic [7:0]  dp_seq,
  output logic        dp_seq_vld,
  output logic        dp_prbs_en,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        err_timeout
);

  localparam int unsigned CHK_MAX = (TIMEOUT_CYC > DET_LAT) ? TIMEOUT_CYC : DET_LAT;
  localparam int unsigned CHK_W   = $clog2(CHK_MAX + 1);

  state_t                state;
  logic [7:0]            n_lat;
  logic [15:0]           len_lat;
  logic [BYTE_IDX_W-1:0] byte_idx;
  logic [7:0]            rep_cnt;
  logic [15:0]           prbs_cnt;
  logic [CHK_W-1:0]      chk_cnt;
  logic [BYTE_IDX_W-1:0] rd_idx;
  logic [7:0]            pat_byte;

  prbs_pat_regs u_pat_regs (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (cfg_wr && (state == ST_IDLE)),
    .wr_addr (cfg_addr),
    .wr_data (cfg_data),
    .rd_idx  (rd_idx),
    .rd_data (pat_byte)
  );

  // dp_seq is registered, so the read index looks one byte ahead of byte_idx.
  always_comb begin
    rd_idx = '0;
    if (state == ST_FEED) begin
      rd_idx = byte_idx + BYTE_IDX_W'(1);
    end
  end

  // Sequencer FSM with registered datapath controls and result flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      n_lat       <= '0;
      len_lat     <= '0;
      byte_idx    <= '0;
      rep_cnt     <= '0;
      prbs_cnt    <= '0;
      chk_cnt     <= '0;
      dp_rst      <= 1'b1;
      dp_seq      <= '0;
      dp_seq_vld  <= 1'b0;
      dp_prbs_en  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      err_timeout <= 1'b0;
    end else if (abort && (state != ST_IDLE)) begin
      state      <= ST_IDLE;
      dp_rst     <= 1'b1;
      dp_seq     <= '0;
      dp_seq_vld <= 1'b0;
      dp_prbs_en <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else begin
      dp_rst <= 1'b0;
      done   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            n_lat       <= N;
            len_lat     <= prbs_len;
            pass        <= 1'b0;
            err_timeout <= 1'b0;
            dp_rst      <= 1'b1;
            busy        <= 1'b1;
            state       <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          byte_idx <= '0;
          rep_cnt  <= '0;
          chk_cnt  <= '0;
          if (n_lat != '0) begin
            dp_seq     <= pat_byte;
            dp_seq_vld <= 1'b1;
            state      <= ST_FEED;
          end else if (len_lat != '0) begin
            prbs_cnt   <= len_lat;
            dp_prbs_en <= 1'b1;
            state      <= ST_PRBS_RUN;
          end else begin
            state <= ST_CHECK;
          end
        end
        ST_FEED: begin
          if ((rep_cnt == n_lat - 8'd1) && (byte_idx == 2'd3)) begin
            dp_seq     <= '0;
            dp_seq_vld <= 1'b0;
            if (len_lat != '0) begin
              prbs_cnt   <= len_lat;
              dp_prbs_en <= 1'b1;
              state      <= ST_PRBS_RUN;
            end else begin
              state <= ST_CHECK;
            end
          end else begin
            byte_idx <= byte_idx + BYTE_IDX_W'(1);
            if (byte_idx == 2'd3) begin
              rep_cnt <= rep_cnt + 8'd1;
            end
            dp_seq <= pat_byte;
          end
        end
        ST_PRBS_RUN: begin
          if (prbs_cnt == 16'd1) begin
            dp_prbs_en <= 1'b0;
            state      <= ST_CHECK;
          end else begin
            prbs_cnt <= prbs_cnt - 16'd1;
          end
        end
        ST_CHECK: begin
`ifdef PRBS_CTRL_TIMEOUT_EN
          if (det_flag) begin
            pass  <= (n_lat != '0);
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_DONE;
          end else if (chk_cnt == CHK_W'(TIMEOUT_CYC - 1)) begin
            err_timeout <= 1'b1;
            pass        <= 1'b0;
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= ST_DONE;
          end else begin
            chk_cnt <= chk_cnt + CHK_W'(1);
          end
`else
          if (chk_cnt == CHK_W'(DET_LAT - 1)) begin
            pass  <= det_flag && (n_lat != '0);
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_DONE;
          end else begin
            chk_cnt <= chk_cnt + CHK_W'(1);
          end
`endif
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prbs_test_ctrl.sv
// Self-checking bench for prbs_test_ctrl: a timeline model (cycle offset since
// the accepted start) predicts every output each cycle; directed runs pin it.
module tb_prbs_test_ctrl;

  localparam int DET_LAT     = 2;
  localparam int TIMEOUT_CYC = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_wr = 1'b0;
  logic [1:0]  cfg_addr = '0;
  logic [7:0]  cfg_data = '0;
  logic [7:0]  N = '0;
  logic [15:0] prbs_len = '0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        det_flag = 1'b0;
  logic        dp_rst;
  logic [7:0]  dp_seq;
  logic        dp_seq_vld;
  logic        dp_prbs_en;
  logic        busy;
  logic        done;
  logic        pass;
  logic        err_timeout;

  prbs_test_ctrl #(.DET_LAT(DET_LAT), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .N(N), .prbs_len(prbs_len), .start(start), .abort(abort), .det_flag(det_flag),
    .dp_rst(dp_rst), .dp_seq(dp_seq), .dp_seq_vld(dp_seq_vld), .dp_prbs_en(dp_prbs_en),
    .busy(busy), .done(done), .pass(pass), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- timeline model ----------------
  // m_t = cycles since the start was accepted (0 = clear cycle), -1 = idle.
  int         m_t = -1;
  int         m_done_at = -1;
  logic [7:0] m_pat [4];
  int         m_n = 0;
  int         m_len = 0;
  logic       m_pass = 1'b0;
  logic       m_err = 1'b0;
  logic       m_rstflag = 1'b1;
  logic       m_valid = 1'b0;

  function automatic int chk_start();
    return 4 * m_n + m_len + 1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_t <= -1;
      m_done_at <= -1;
      for (int i = 0; i < 4; i++) m_pat[i] <= 8'h00;
      m_pass <= 1'b0;
      m_err <= 1'b0;
      m_rstflag <= 1'b1;
      m_valid <= 1'b1;
    end else if (m_t >= 0 && abort) begin
      m_t <= -1;
      m_done_at <= -1;
      m_pass <= 1'b0;
      m_rstflag <= 1'b1;
    end else if (m_t < 0) begin
      m_rstflag <= 1'b0;
      if (cfg_wr) m_pat[cfg_addr] <= cfg_data;
      if (start) begin
        m_n <= int'(N);
        m_len <= int'(prbs_len);
        m_pass <= 1'b0;
        m_err <= 1'b0;
        m_t <= 0;
        m_done_at <= -1;
      end
    end else if (m_t == m_done_at) begin
      m_t <= -1;
      m_done_at <= -1;
    end else begin
      m_t <= m_t + 1;
      if (m_t >= chk_start() && m_done_at < 0) begin
`ifdef PRBS_CTRL_TIMEOUT_EN
        if (det_flag) begin
          m_pass <= (m_n != 0);
          m_done_at <= m_t + 1;
        end else if (m_t - chk_start() == TIMEOUT_CYC - 1) begin
          m_err <= 1'b1;
          m_pass <= 1'b0;
          m_done_at <= m_t + 1;
        end
`else
        if (m_t == chk_start() + DET_LAT - 1) begin
          m_pass <= det_flag && (m_n != 0);
          m_done_at <= m_t + 1;
        end
`endif
      end
    end
  end

  // Expected output bundle: {dp_rst, busy, done, pass, err, vld, prbs_en, seq}
  function automatic logic [14:0] expected();
    logic e_rst, e_busy, e_done, e_vld, e_prbs;
    logic [7:0] e_seq;
    e_rst = 0; e_busy = 0; e_done = 0; e_vld = 0; e_prbs = 0; e_seq = 8'h00;
    if (m_t < 0) begin
      e_rst = m_rstflag;
    end else if (m_t == m_done_at) begin
      e_done = 1;
    end else if (m_t == 0) begin
      e_rst = 1; e_busy = 1;
    end else if (m_t <= 4 * m_n) begin
      e_busy = 1; e_vld = 1; e_seq = m_pat[(m_t - 1) % 4];
    end else if (m_t <= 4 * m_n + m_len) begin
      e_busy = 1; e_prbs = 1;
    end else begin
      e_busy = 1;
    end
    return {e_rst, e_busy, e_done, m_pass, m_err, e_vld, e_prbs, e_seq};
  endfunction

  // Per-cycle compare plus activity counters used by the directed checks.
  int         vld_cnt = 0;
  int         prbs_cnt = 0;
  int         done_cnt = 0;
  int         busy_cnt = 0;
  logic [7:0] seq_log [$];

  always @(negedge clk) begin
    if (m_valid) begin
      check("outputs", {17'd0, dp_rst, busy, done, pass, err_timeout, dp_seq_vld, dp_prbs_en, dp_seq},
            {17'd0, expected()});
      if (dp_seq_vld) begin vld_cnt++; seq_log.push_back(dp_seq); end
      if (dp_prbs_en) prbs_cnt++;
      if (done) done_cnt++;
      if (busy) busy_cnt++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clr_counts();
    vld_cnt = 0; prbs_cnt = 0; done_cnt = 0; busy_cnt = 0;
    seq_log.delete();
  endtask

  task automatic write_pat(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3);
    logic [7:0] b [4];
    b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
    for (int i = 0; i < 4; i++) begin
      cfg_wr = 1; cfg_addr = 2'(i); cfg_data = b[i];
      tick();
    end
    cfg_wr = 0;
  endtask

  task automatic do_start(input int n, input int len);
    N = 8'(n); prbs_len = 16'(len); start = 1;
    tick();
    start = 0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (!busy && m_t < 0) begin ok = 1; break; end
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL %s_timeout actual=busy required=idle_within_%0d", name, budget);
    end
  endtask

  task automatic wait_vld(input int target, input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (vld_cnt == target) begin ok = 1; break; end
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL wait_vld actual=%0d required=%0d", vld_cnt, target);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] exp_pat [4];
    bit         seq_ok;
    exp_pat[0] = 8'hAB; exp_pat[1] = 8'hCD; exp_pat[2] = 8'hEF; exp_pat[3] = 8'h23;

    rst = 1;
    repeat (3) tick();
    @(negedge clk);
    check("reset_dp_rst", 32'(dp_rst), 32'd1);
    check("reset_outs", {25'd0, busy, done, pass, err_timeout, dp_seq_vld, dp_prbs_en, 1'b0},
          32'd0);
    tick();
    rst = 0;
    tick();
    check("post_reset_dp_rst", 32'(dp_rst), 32'd0);

    // Full run with detector match.
    write_pat(8'hAB, 8'hCD, 8'hEF, 8'h23);
    det_flag = 1;
    clr_counts();
    do_start(5, 10);
    wait_idle("run1", 200);
    check("run1_vld_cycles", 32'(vld_cnt), 32'd20);
    seq_ok = (seq_log.size() == 20);
    for (int i = 0; i < seq_log.size(); i++) if (seq_log[i] !== exp_pat[i % 4]) seq_ok = 0;
    check("run1_byte_order", 32'(seq_ok), 32'd1);
    check("run1_prbs_cycles", 32'(prbs_cnt), 32'd10);
    check("run1_done_pulses", 32'(done_cnt), 32'd1);
    check("run1_pass", 32'(pass), 32'd1);

    // Detector never fires.
    write_pat(8'hAB, 8'hBD, 8'hEF, 8'h23);
    det_flag = 0;
    clr_counts();
    do_start(3, 4);
    wait_idle("run2", 200);
    check("run2_vld_cycles", 32'(vld_cnt), 32'd12);
    check("run2_pass", 32'(pass), 32'd0);
`ifdef PRBS_CTRL_TIMEOUT_EN
    check("run2_err_timeout", 32'(err_timeout), 32'd1);
`endif

    // N=0, prbs_len=0: clear, check, done.
    det_flag = 1;
    clr_counts();
    do_start(0, 0);
    wait_idle("run3", 200);
    check("run3_vld_cycles", 32'(vld_cnt), 32'd0);
    check("run3_pass", 32'(pass), 32'd0);
`ifdef PRBS_CTRL_TIMEOUT_EN
    check("run3_busy_cycles", 32'(busy_cnt), 32'd2);
`else
    check("run3_busy_cycles", 32'(busy_cnt), 32'(1 + DET_LAT));
`endif

    // Start re-pulsed during FEED is ignored.
    write_pat(8'hAB, 8'hCD, 8'hEF, 8'h23);
    clr_counts();
    do_start(2, 3);
    wait_vld(3, 20);
    start = 1; N = 8'd7;
    tick();
    start = 0;
    wait_idle("run4", 200);
    check("run4_vld_cycles", 32'(vld_cnt), 32'd8);

    // Abort on the 7th FEED cycle.
    clr_counts();
    do_start(3, 5);
    wait_vld(7, 20);
    abort = 1;
    tick();
    abort = 0;
    @(negedge clk); #1;
    check("abort_dp_rst", 32'(dp_rst), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    repeat (4) tick();
    check("abort_vld_cycles", 32'(vld_cnt), 32'd7);
    check("abort_no_done", 32'(done_cnt), 32'd0);
    check("abort_pass", 32'(pass), 32'd0);

    // cfg_wr while busy leaves the pattern untouched.
    do_start(2, 0);
    cfg_wr = 1; cfg_addr = 2'd1; cfg_data = 8'h55;
    tick();
    cfg_wr = 0;
    wait_idle("run6a", 200);
    clr_counts();
    do_start(1, 0);
    wait_idle("run6b", 200);
    check("busy_write_ignored", 32'(seq_log.size() > 1 ? seq_log[1] : 8'hXX), 32'hCD);

    // Randomized runs with random pattern writes, det_flag, stray starts, aborts.
    for (int r = 0; r < 60; r++) begin
      bit ok;
      write_pat(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      do_start(int'($urandom_range(0, 6)), int'($urandom_range(0, 20)));
      ok = 0;
      for (int c = 0; c < 400; c++) begin
        det_flag = 1'($urandom);
        cfg_wr = ($urandom_range(0, 3) == 0);
        cfg_addr = 2'($urandom);
        cfg_data = 8'($urandom);
        start = ($urandom_range(0, 15) == 0);
        N = 8'($urandom_range(0, 6));
        prbs_len = 16'($urandom_range(0, 20));
        abort = ($urandom_range(0, 49) == 0);
        tick();
        start = 0; abort = 0; cfg_wr = 0;
        @(negedge clk); #1;
        if (!busy && m_t < 0) begin ok = 1; break; end
      end
      if (!ok) begin
        n_tests++; n_fail++;
        $display("FAIL rand_run_timeout actual=busy required=idle run=%0d", r);
      end
    end

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
